// File: rtl/shift_feed_writer_if.sv
// Bus bundle for shift_feed_writer: the 1-cycle-latency memory read port
// and the write_en/data_in pair that feeds the 3-deep shift chain.
interface shift_feed_writer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              shift_write_en;
  logic [DATA_W-1:0] shift_data;
  logic              line_end;

  // Writer side: drives reads and the chain, consumes read data.
  modport master (
    output mem_rd_en, mem_addr, shift_write_en, shift_data, line_end,
    input  mem_rd_data
  );

  // Memory/chain side.
  modport slave (
    input  mem_rd_en, mem_addr, shift_write_en, shift_data, line_end,
    output mem_rd_data
  );
endinterface

// File: rtl/shift_feed_writer.sv
// shift_feed_writer: streams one frame of pixel words from a 1-cycle-latency
// read port into the shift chain, one word per accepted cycle, honouring a
// downstream stall through a 1-entry skid.
// Optional feature macro: FEED_PAD_EN -- when defined, two zero words are
// emitted after every line to flush the 3-deep chain; line_end then marks
// the second pad word.
module shift_feed_writer #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 160,
  parameter int LINES          = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  shift_feed_writer_if.master bus
);

`ifdef FEED_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int TOTAL = WORDS_PER_LINE * LINES;
  localparam int WI_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LI_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int LIN_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [LIN_W-1:0]  lin_idx;    // reads issued so far in this frame
  logic [WI_W-1:0]   rd_word;    // word position of the next read in its line
  logic              line_hold;  // reads paused while a line's pads go out
  logic              pending;    // read data arrives this cycle
  logic              skid_vld;
  logic [DATA_W-1:0] skid_data;
  logic [WI_W-1:0]   word_idx;   // emit-side word position
  logic [LI_W-1:0]   line_idx;   // emit-side line count
  logic [1:0]        pad_left;
  logic              wr_en_q;
  logic [DATA_W-1:0] data_q;
  logic              line_end_q;
  logic              busy_q;
  logic              done_q;

  logic issue, take_ret, take_skid, take_pad;
  logic last_word, last_rd, rd_last_of_line;

  // Issue only when the return can be absorbed: no stall and an empty skid,
  // so a skid fill can never collide with another return.
  always_comb begin
    issue           = (state == STREAM) && !stall && !skid_vld && !line_hold;
    take_ret        = pending && !stall;
    take_skid       = skid_vld && !stall;
    take_pad        = PAD_EN && !pending && !skid_vld && (pad_left != 2'd0) && !stall;
    last_word       = (word_idx == WI_W'(WORDS_PER_LINE - 1));
    last_rd         = (lin_idx == LIN_W'(TOTAL - 1));
    rd_last_of_line = (rd_word == WI_W'(WORDS_PER_LINE - 1));
  end

  assign bus.mem_rd_en      = issue;
  assign bus.mem_addr       = base_q + ADDR_W'(lin_idx);
  assign bus.shift_write_en = wr_en_q;
  assign bus.shift_data     = data_q;
  assign bus.line_end       = line_end_q;
  assign busy               = busy_q;
  assign done               = done_q;

  // Frame FSM, read issue, skid and registered emit path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      lin_idx    <= '0;
      rd_word    <= '0;
      line_hold  <= 1'b0;
      pending    <= 1'b0;
      skid_vld   <= 1'b0;
      skid_data  <= '0;
      word_idx   <= '0;
      line_idx   <= '0;
      pad_left   <= 2'd0;
      wr_en_q    <= 1'b0;
      data_q     <= '0;
      line_end_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_en_q    <= 1'b0;
      line_end_q <= 1'b0;
      done_q     <= 1'b0;
      pending    <= issue;

      if (issue) begin
        lin_idx <= lin_idx + 1'b1;
        rd_word <= rd_last_of_line ? '0 : rd_word + 1'b1;
        if (PAD_EN && rd_last_of_line) line_hold <= 1'b1;
      end

      // A stalled return parks in the skid; it leaves as soon as stall drops.
      if (pending && stall) begin
        skid_vld  <= 1'b1;
        skid_data <= bus.mem_rd_data;
      end else if (take_skid) begin
        skid_vld <= 1'b0;
      end

      if (take_ret || take_skid) begin
        wr_en_q    <= 1'b1;
        data_q     <= take_ret ? bus.mem_rd_data : skid_data;
        line_end_q <= !PAD_EN && last_word;
        if (last_word) begin
          word_idx <= '0;
          line_idx <= line_idx + 1'b1;
          if (PAD_EN) pad_left <= 2'd2;
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end else if (take_pad) begin
        wr_en_q  <= 1'b1;
        data_q   <= '0;
        pad_left <= pad_left - 2'd1;
        if (pad_left == 2'd1) begin
          line_end_q <= 1'b1;
          line_hold  <= 1'b0;
        end
      end

      case (state)
        IDLE: if (start) begin
          state    <= STREAM;
          base_q   <= base_addr;
          lin_idx  <= '0;
          rd_word  <= '0;
          word_idx <= '0;
          line_idx <= '0;
          busy_q   <= 1'b1;
        end
        STREAM: if (issue && last_rd) state <= DRAIN;
        DRAIN: if (!pending && !skid_vld && (pad_left == 2'd0)) begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_feed_writer.sv
// Scoreboard bench for shift_feed_writer (W=4, L=2): stimulus pushes the
// expected word stream, a negedge monitor pops and compares every emit.
module tb_shift_feed_writer;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int L  = 2;
`ifdef FEED_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic          le;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start, stall, busy, done;
  logic [AW-1:0] base_addr;
  int            cyc = 0;

  shift_feed_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  shift_feed_writer #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(W), .LINES(L)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stall(stall),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: mem[a] = a, one cycle of read latency.
  initial bus.mem_rd_data = '0;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= DW'(bus.mem_addr);

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  int   emitted, done_cnt, first_emit_cyc, last_emit_cyc, done_cyc, start_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every emitted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.shift_write_en) begin
      exp_t e;
      emitted++;
      if (emitted == 1) first_emit_cyc = cyc;
      last_emit_cyc = cyc;
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL extra_word: got %0h expected no word", bus.shift_data);
      end else begin
        e = q.pop_front();
        chk("word_data", 64'(bus.shift_data), 64'(e.d));
        chk("line_end", 64'(bus.line_end), 64'(e.le));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [AW-1:0] b);
    for (int l = 0; l < L; l++) begin
      for (int w = 0; w < W; w++) begin
        logic [AW-1:0] a;
        a = b + AW'(l * W + w);
        q.push_back('{d: DW'(a), le: (w == W - 1) && !PAD});
      end
      if (PAD) begin
        q.push_back('{d: '0, le: 1'b0});
        q.push_back('{d: '0, le: 1'b1});
      end
    end
  endtask

  task automatic begin_frame(input logic [AW-1:0] b);
    push_frame(b);
    emitted  = 0;
    done_cnt = 0;
    tick();
    base_addr = b;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
    base_addr = 16'hDEAD;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Runs one frame; optionally stalls 3 cycles on the return of word base+2,
  // and optionally re-pulses start mid-frame (must be ignored).
  task automatic run_frame(input logic [AW-1:0] b, input bit do_stall, input bit do_restart);
    bit armed = do_stall, arm_next = 1'b0, restarted = 1'b0;
    int stall_left = 0;
    begin_frame(b);
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      tick();
      start = 1'b0;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end
      if (arm_next) begin
        stall      = 1'b1;
        stall_left = 3;
        arm_next   = 1'b0;
      end
      if (armed && bus.mem_rd_en && bus.mem_addr == b + AW'(2)) begin
        arm_next = 1'b1;
        armed    = 1'b0;
      end
      if (do_restart && !restarted && emitted == 4) begin
        base_addr = 16'h0100;
        start     = 1'b1;
        restarted = 1'b1;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    if (done_cnt == 0) begin
      n_chk++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
    repeat (3) tick();
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("words_left", 64'(q.size()), 64'd0);
    chk("emit_count", 64'(emitted), 64'((W + (PAD ? 2 : 0)) * L));
    chk("done_after_last", 64'(done_cyc - last_emit_cyc), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; base_addr = '0;
    repeat (3) tick();
    chk("reset_outputs",
        64'({bus.mem_rd_en, bus.mem_addr, bus.shift_write_en, bus.shift_data, bus.line_end, busy, done}),
        64'd0);
    rst = 1'b0;

    // 1: plain frame, latency and back-to-back throughput
    run_frame(16'h0010, 1'b0, 1'b0);
    chk("start_latency", 64'(first_emit_cyc - start_cyc), 64'd3);
    if (!PAD) chk("throughput", 64'(last_emit_cyc - first_emit_cyc), 64'(W * L - 1));

    // 2: stall on the return of 0x12 -> skid keeps order and count
    run_frame(16'h0010, 1'b1, 1'b0);

    // 3: address wraps past 0xFFFF
    run_frame(16'hFFFE, 1'b0, 1'b0);

    // 4: start mid-frame is ignored
    run_frame(16'h0040, 1'b0, 1'b1);

    // 5: reset after the 3rd word aborts; in-flight return is dropped
    begin_frame(16'h0020);
    for (int i = 0; i < 50 && emitted < 3; i++) tick();
    chk("words_before_rst", 64'(emitted), 64'd3);
    rst = 1'b1;
    tick();
    chk("rst_outputs",
        64'({bus.mem_rd_en, bus.mem_addr, bus.shift_write_en, bus.shift_data, bus.line_end, busy, done}),
        64'd0);
    q.delete();
    rst = 1'b0;
    repeat (5) tick();
    chk("no_done_after_rst", 64'(done_cnt), 64'd0);
    run_frame(16'h0030, 1'b0, 1'b0);
    chk("clean_latency", 64'(first_emit_cyc - start_cyc), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
